// File: rtl/pm_wb_arbiter.sv
// Three-master Wishbone arbiter in front of the power_manager register slave.
// Ports: wb_clk_i/wb_rst_n_i; m_* master side (bit/slice k = master k);
//        s_* slave side; grant_o/grant_valid_o owner; timeout_count_o aborts.
module pm_wb_arbiter #(
  parameter logic [15:0] TIMEOUT     = 16'd1023,
  parameter bit          PRIORITY_M2 = 1'b0
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_n_i,
  input  logic [2:0]  m_cyc_i,
  input  logic [2:0]  m_stb_i,
  input  logic [2:0]  m_we_i,
  input  logic [47:0] m_adr_i,
  input  logic [47:0] m_dat_i,
  output logic [15:0] m_dat_o,
  output logic [2:0]  m_ack_o,
  output logic [2:0]  m_err_o,
  output logic        s_cyc_o,
  output logic        s_stb_o,
  output logic        s_we_o,
  output logic [15:0] s_adr_o,
  output logic [15:0] s_dat_o,
  input  logic [15:0] s_dat_i,
  input  logic        s_ack_i,
  output logic [1:0]  grant_o,
  output logic        grant_valid_o,
  output logic [7:0]  timeout_count_o
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_OWNED,
    S_ABORT
  } state_t;

  state_t      r_state;
  logic [1:0]  r_grant;
  logic        r_gv;
  logic [1:0]  r_last;
  logic [15:0] r_tcnt;
  logic [7:0]  r_tocnt;

  logic [1:0]  w_p1;
  logic [1:0]  w_p2;
  logic [1:0]  w_win;
  logic        w_cyc;
  logic        w_stb;
  logic        w_we;
  logic [15:0] w_adr;
  logic [15:0] w_dat;
  logic        w_owned;
  logic        w_stall;
  logic [15:0] w_tnext;

  // Round-robin search order: last+1, last+2, last (mod 3).
  always_comb begin
    w_p1  = (r_last == 2'd2) ? 2'd0 : r_last + 2'd1;
    w_p2  = (w_p1 == 2'd2) ? 2'd0 : w_p1 + 2'd1;
    w_win = r_last;
    if (m_cyc_i[w_p1])
      w_win = w_p1;
    else if (m_cyc_i[w_p2])
      w_win = w_p2;
    if (PRIORITY_M2 && m_cyc_i[2])
      w_win = 2'd2;
  end

  always_comb begin
    w_cyc = m_cyc_i[0];
    w_stb = m_stb_i[0];
    w_we  = m_we_i[0];
    w_adr = m_adr_i[15:0];
    w_dat = m_dat_i[15:0];
    unique case (r_grant)
      2'd1: begin
        w_cyc = m_cyc_i[1];
        w_stb = m_stb_i[1];
        w_we  = m_we_i[1];
        w_adr = m_adr_i[31:16];
        w_dat = m_dat_i[31:16];
      end
      2'd2: begin
        w_cyc = m_cyc_i[2];
        w_stb = m_stb_i[2];
        w_we  = m_we_i[2];
        w_adr = m_adr_i[47:32];
        w_dat = m_dat_i[47:32];
      end
      default: ;
    endcase
  end

  assign w_owned = (r_state == S_OWNED);
  assign w_stall = w_stb & ~s_ack_i;
  assign w_tnext = r_tcnt + 16'd1;

  assign s_cyc_o = w_owned & w_cyc;
  assign s_stb_o = w_owned & w_stb;
  assign s_we_o  = w_owned & w_we;
  assign s_adr_o = w_adr;
  assign s_dat_o = w_dat;
  assign m_dat_o = s_dat_i;

  // Ack only reaches the owner; acks outside OWNED are dropped.
  assign m_ack_o = w_owned ? (3'(s_ack_i) << r_grant) : 3'b000;
  assign m_err_o = (r_state == S_ABORT) ? (3'b001 << r_grant) : 3'b000;

  assign grant_o         = r_grant;
  assign grant_valid_o   = r_gv;
  assign timeout_count_o = r_tocnt;

  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_n_i) begin
      r_state <= S_IDLE;
      r_grant <= 2'd0;
      r_gv    <= 1'b0;
      r_last  <= 2'd2;
      r_tcnt  <= 16'd0;
      r_tocnt <= 8'd0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          r_tcnt <= 16'd0;
          if (|m_cyc_i) begin
            r_state <= S_OWNED;
            r_grant <= w_win;
            r_gv    <= 1'b1;
          end
        end
        S_OWNED: begin
          if (!w_cyc) begin
            r_state <= S_IDLE;
            r_gv    <= 1'b0;
            r_last  <= r_grant;
            r_tcnt  <= 16'd0;
          end else if (w_stall) begin
            r_tcnt <= w_tnext;
            if (w_tnext == TIMEOUT) begin
              r_state <= S_ABORT;
              if (r_tocnt != 8'hFF)
                r_tocnt <= r_tocnt + 8'd1;
            end
          end else begin
            r_tcnt <= 16'd0;
          end
        end
        S_ABORT: begin
          r_state <= S_IDLE;
          r_gv    <= 1'b0;
          r_last  <= r_grant;
          r_tcnt  <= 16'd0;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pm_wb_arbiter.sv
// Directed testbench for pm_wb_arbiter.
// Two instances: round-robin (rr) and master-2 priority (pr), TIMEOUT=8.
module tb_pm_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  cyc, stb, we;
  logic [47:0] adr, dat;

  logic [15:0] rr_mdat, rr_sadr, rr_sdat, rr_sdati;
  logic [2:0]  rr_mack, rr_merr;
  logic        rr_scyc, rr_sstb, rr_swe, rr_sack, rr_gv;
  logic [1:0]  rr_grant;
  logic [7:0]  rr_tc;
  logic        rr_ackr, rr_acken, ack_force;

  logic [15:0] pr_mdat, pr_sadr, pr_sdat, pr_sdati;
  logic [2:0]  pr_mack, pr_merr;
  logic        pr_scyc, pr_sstb, pr_swe, pr_sack, pr_gv;
  logic [1:0]  pr_grant;
  logic [7:0]  pr_tc;
  logic        pr_ackr, pr_acken;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  assign rr_sdati = rr_sadr ^ 16'h5A5A;
  assign rr_sack  = rr_ackr | ack_force;
  assign pr_sdati = pr_sadr ^ 16'h5A5A;
  assign pr_sack  = pr_ackr;

  // Registered-ack slave models
  always @(posedge clk) begin
    if (!rst_n) rr_ackr <= 1'b0;
    else rr_ackr <= rr_acken & rr_scyc & rr_sstb & ~rr_ackr;
  end
  always @(posedge clk) begin
    if (!rst_n) pr_ackr <= 1'b0;
    else pr_ackr <= pr_acken & pr_scyc & pr_sstb & ~pr_ackr;
  end

  pm_wb_arbiter #(.TIMEOUT(16'd8), .PRIORITY_M2(1'b0)) u_rr (
    .wb_clk_i(clk), .wb_rst_n_i(rst_n),
    .m_cyc_i(cyc), .m_stb_i(stb), .m_we_i(we),
    .m_adr_i(adr), .m_dat_i(dat),
    .m_dat_o(rr_mdat), .m_ack_o(rr_mack), .m_err_o(rr_merr),
    .s_cyc_o(rr_scyc), .s_stb_o(rr_sstb), .s_we_o(rr_swe),
    .s_adr_o(rr_sadr), .s_dat_o(rr_sdat), .s_dat_i(rr_sdati),
    .s_ack_i(rr_sack), .grant_o(rr_grant), .grant_valid_o(rr_gv),
    .timeout_count_o(rr_tc)
  );

  pm_wb_arbiter #(.TIMEOUT(16'd8), .PRIORITY_M2(1'b1)) u_pr (
    .wb_clk_i(clk), .wb_rst_n_i(rst_n),
    .m_cyc_i(cyc), .m_stb_i(stb), .m_we_i(we),
    .m_adr_i(adr), .m_dat_i(dat),
    .m_dat_o(pr_mdat), .m_ack_o(pr_mack), .m_err_o(pr_merr),
    .s_cyc_o(pr_scyc), .s_stb_o(pr_sstb), .s_we_o(pr_swe),
    .s_adr_o(pr_sadr), .s_dat_o(pr_sdat), .s_dat_i(pr_sdati),
    .s_ack_i(pr_sack), .grant_o(pr_grant), .grant_valid_o(pr_gv),
    .timeout_count_o(pr_tc)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    cyc = 3'b000;
    stb = 3'b000;
    ack_force = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({rr_grant, rr_gv, rr_scyc, rr_sstb} !== 5'b0) begin
      errors++;
      $display("FAIL reset_ctl: got %b want 00000",
               {rr_grant, rr_gv, rr_scyc, rr_sstb});
    end
    checks++;
    if ({rr_mack, rr_merr, rr_tc} !== 14'b0) begin
      errors++;
      $display("FAIL reset_ack_err_tc: got %h want 0",
               {rr_mack, rr_merr, rr_tc});
    end
  endtask

  task automatic test_single();
    do_reset();
    rr_acken = 1'b1;
    pr_acken = 1'b1;
    adr = 48'h1111_0000_2222;
    we = 3'b000;
    cyc = 3'b010;
    stb = 3'b010;
    step();
    checks++;
    if ({rr_scyc, rr_sstb, rr_gv, rr_grant, rr_mack} !== 8'b111_01_000) begin
      errors++;
      $display("FAIL single_grant: got %b want 11101000",
               {rr_scyc, rr_sstb, rr_gv, rr_grant, rr_mack});
    end
    step();
    checks++;
    if (rr_mack !== 3'b010) begin
      errors++;
      $display("FAIL single_ack: got %b want 010", rr_mack);
    end
    checks++;
    if (rr_mdat !== 16'h5A5A) begin
      errors++;
      $display("FAIL single_dat: got %h want 5a5a", rr_mdat);
    end
    cyc = 3'b000;
    stb = 3'b000;
    step();
    checks++;
    if ({rr_gv, rr_grant, rr_scyc} !== 4'b0010) begin
      errors++;
      $display("FAIL single_release: got %b want 0010",
               {rr_gv, rr_grant, rr_scyc});
    end
  endtask

  task automatic test_round_robin();
    int exp_g[5] = '{0, 1, 2, 0, 1};
    logic [15:0] exp_d;
    int n;
    do_reset();
    rr_acken = 1'b1;
    adr = 48'h0300_0200_0100;
    cyc = 3'b111;
    stb = 3'b111;
    for (int i = 0; i < 5; i++) begin
      step();
      checks++;
      if (rr_gv !== 1'b1 || rr_grant !== 2'(exp_g[i])) begin
        errors++;
        $display("FAIL rr_grant[%0d]: got v=%b g=%0d want v=1 g=%0d",
                 i, rr_gv, rr_grant, exp_g[i]);
      end
      n = 0;
      while (rr_mack === 3'b000 && n < 20) begin
        step();
        n++;
      end
      exp_d = 16'h5A5A ^ (16'h0100 << (exp_g[i]));
      exp_d = 16'h5A5A ^ (16'h0100 * 16'(exp_g[i] + 1));
      checks++;
      if (rr_mack !== (3'b001 << exp_g[i]) || rr_mdat !== exp_d) begin
        errors++;
        $display("FAIL rr_ack[%0d]: got ack=%b dat=%h want ack=%b dat=%h",
                 i, rr_mack, rr_mdat, 3'b001 << exp_g[i], exp_d);
      end
      cyc[exp_g[i]] = 1'b0;
      stb[exp_g[i]] = 1'b0;
      step();
      checks++;
      if (rr_gv !== 1'b0) begin
        errors++;
        $display("FAIL rr_idle[%0d]: got %b want 0", i, rr_gv);
      end
      cyc[exp_g[i]] = 1'b1;
      stb[exp_g[i]] = 1'b1;
    end
    cyc = 3'b000;
    stb = 3'b000;
    step();
  endtask

  task automatic test_priority();
    int n;
    do_reset();
    pr_acken = 1'b1;
    cyc = 3'b101;
    stb = 3'b101;
    for (int r = 0; r < 4; r++) begin
      step();
      checks++;
      if (pr_gv !== 1'b1 || pr_grant !== 2'd2) begin
        errors++;
        $display("FAIL prio_grant[%0d]: got v=%b g=%0d want v=1 g=2",
                 r, pr_gv, pr_grant);
      end
      n = 0;
      while (pr_mack === 3'b000 && n < 20) begin
        step();
        n++;
      end
      checks++;
      if (pr_mack !== 3'b100) begin
        errors++;
        $display("FAIL prio_ack[%0d]: got %b want 100", r, pr_mack);
      end
      cyc[2] = 1'b0;
      stb[2] = 1'b0;
      step();
      if (r < 3) begin
        cyc[2] = 1'b1;
        stb[2] = 1'b1;
      end
    end
    step();
    checks++;
    if (pr_gv !== 1'b1 || pr_grant !== 2'd0) begin
      errors++;
      $display("FAIL prio_m0: got v=%b g=%0d want v=1 g=0", pr_gv, pr_grant);
    end
    cyc = 3'b000;
    stb = 3'b000;
    step();
  endtask

  task automatic test_timeout();
    int bad;
    do_reset();
    rr_acken = 1'b0;
    cyc = 3'b011;
    stb = 3'b011;
    step();
    bad = 0;
    for (int k = 1; k <= 8; k++) begin
      if (rr_merr !== 3'b000 || rr_scyc !== 1'b1 || rr_grant !== 2'd0) bad++;
      step();
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL to_stall: got %0d bad cycles want 0", bad);
    end
    checks++;
    if ({rr_merr, rr_scyc, rr_mack, rr_tc} !== {3'b001, 1'b0, 3'b000, 8'd1}) begin
      errors++;
      $display("FAIL to_abort: got err=%b cyc=%b ack=%b tc=%0d want 001 0 000 1",
               rr_merr, rr_scyc, rr_mack, rr_tc);
    end
    step();
    checks++;
    if (rr_merr !== 3'b000 || rr_gv !== 1'b0) begin
      errors++;
      $display("FAIL to_idle: got err=%b v=%b want 000 0", rr_merr, rr_gv);
    end
    step();
    checks++;
    if (rr_gv !== 1'b1 || rr_grant !== 2'd1) begin
      errors++;
      $display("FAIL to_next: got v=%b g=%0d want v=1 g=1", rr_gv, rr_grant);
    end
    cyc = 3'b000;
    stb = 3'b000;
    step();
  endtask

  task automatic test_saturate();
    int pulses;
    int dbl;
    bit prev;
    do_reset();
    rr_acken = 1'b0;
    cyc = 3'b001;
    stb = 3'b001;
    pulses = 0;
    dbl = 0;
    prev = 1'b0;
    for (int i = 0; i < 3500 && pulses < 300; i++) begin
      step();
      if (rr_merr !== 3'b000) begin
        if (prev) dbl++;
        pulses++;
        if (pulses == 255) begin
          checks++;
          if (rr_tc !== 8'd255) begin
            errors++;
            $display("FAIL sat_255: got %0d want 255", rr_tc);
          end
        end
        if (pulses == 256) begin
          checks++;
          if (rr_tc !== 8'd255) begin
            errors++;
            $display("FAIL sat_256: got %0d want 255", rr_tc);
          end
        end
      end
      prev = (rr_merr !== 3'b000);
    end
    checks++;
    if (pulses != 300 || dbl != 0) begin
      errors++;
      $display("FAIL sat_pulses: got %0d pulses %0d doubles want 300 0",
               pulses, dbl);
    end
    checks++;
    if (rr_tc !== 8'd255) begin
      errors++;
      $display("FAIL sat_final: got %0d want 255", rr_tc);
    end
    cyc = 3'b000;
    stb = 3'b000;
    step();
  endtask

  task automatic test_reset_mid();
    do_reset();
    rr_acken = 1'b1;
    cyc = 3'b100;
    stb = 3'b100;
    step();
    checks++;
    if (rr_grant !== 2'd2 || rr_scyc !== 1'b1) begin
      errors++;
      $display("FAIL rst_own: got g=%0d cyc=%b want 2 1", rr_grant, rr_scyc);
    end
    rst_n = 1'b0;
    step();
    ack_force = 1'b1;
    checks++;
    if ({rr_mack, rr_merr, rr_scyc, rr_sstb, rr_gv, rr_grant, rr_tc}
        !== 19'b0) begin
      errors++;
      $display("FAIL rst_mid: got ack=%b err=%b cyc=%b v=%b g=%0d tc=%0d",
               rr_mack, rr_merr, rr_scyc, rr_gv, rr_grant, rr_tc);
    end
    step();
    checks++;
    if (rr_mack !== 3'b000 || rr_scyc !== 1'b0) begin
      errors++;
      $display("FAIL rst_late_ack: got ack=%b cyc=%b want 000 0",
               rr_mack, rr_scyc);
    end
    rst_n = 1'b1;
    ack_force = 1'b0;
    cyc = 3'b111;
    stb = 3'b111;
    step();
    checks++;
    if (rr_gv !== 1'b1 || rr_grant !== 2'd0) begin
      errors++;
      $display("FAIL rst_first: got v=%b g=%0d want v=1 g=0", rr_gv, rr_grant);
    end
    cyc = 3'b000;
    stb = 3'b000;
    step();
  endtask

  initial begin
    rst_n = 1'b0;
    cyc = 3'b000;
    stb = 3'b000;
    we = 3'b000;
    adr = 48'h0;
    dat = 48'h0;
    rr_acken = 1'b0;
    pr_acken = 1'b0;
    ack_force = 1'b0;
    test_reset();
    test_single();
    test_round_robin();
    test_priority();
    test_timeout();
    test_saturate();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
